// File: rtl/beta_operand_stage_if.sv
// Handshake and operand bus for the Beta operand-fetch stage.
// master drives instr/writeback/out_ready, slave is the stage.
interface beta_operand_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  alu_fn;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  rc;
  logic        illegal;

  modport master (
    output in_valid, instr,
    output wb_en, wb_addr, wb_data,
    output out_ready,
    input  in_ready, out_valid,
    input  alu_fn, op_a, op_b, rc, illegal
  );

  modport slave (
    input  in_valid, instr,
    input  wb_en, wb_addr, wb_data,
    input  out_ready,
    output in_ready, out_valid,
    output alu_fn, op_a, op_b, rc, illegal
  );
endinterface

// File: rtl/beta_operand_stage.sv
// Beta operand stage: regfile read, OP/OPC decode, one output register.
// Define BETA_OPERAND_BYPASS_EN to forward same-edge writeback data.
module beta_operand_stage #(
  parameter logic [31:0] REG_INIT = 32'h0
) (
  input logic clk,
  input logic rst,
  beta_operand_stage_if.slave bus
);

  logic [31:0] rf [0:30];

  logic [5:0]  opc;
  logic [4:0]  ra;
  logic [4:0]  rb;
  logic [15:0] lit;

  assign opc = bus.instr[31:26];
  assign ra  = bus.instr[20:16];
  assign rb  = bus.instr[15:11];
  assign lit = bus.instr[15:0];

  logic fwd_a;
  logic fwd_b;

`ifdef BETA_OPERAND_BYPASS_EN
  assign fwd_a = bus.wb_en && (bus.wb_addr == ra)
                 && (ra != 5'd31);
  assign fwd_b = bus.wb_en && (bus.wb_addr == rb)
                 && (rb != 5'd31);
`else
  assign fwd_a = 1'b0;
  assign fwd_b = 1'b0;
`endif

  logic [31:0] src_a;
  logic [31:0] src_b;

  always_comb begin
    src_a = 32'h0;
    src_b = 32'h0;
    if (ra != 5'd31) src_a = rf[ra];
    if (rb != 5'd31) src_b = rf[rb];
    if (fwd_a) src_a = bus.wb_data;
    if (fwd_b) src_b = bus.wb_data;
  end

  logic bad;
  logic is_op;
  logic is_opc;

  assign bad = !opc[5]
             || (opc[3:0] == 4'h3)
             || (opc[3:0] == 4'h7)
             || (opc[3:0] == 4'hF);
  assign is_op  = !bad && !opc[4];
  assign is_opc = !bad &&  opc[4];

  logic [3:0]  n_fn;
  logic [31:0] n_a;
  logic [31:0] n_b;
  logic        n_ill;

  always_comb begin
    n_fn  = 4'h0;
    n_a   = 32'h0;
    n_b   = 32'h0;
    n_ill = 1'b0;
    unique case (1'b1)
      bad: n_ill = 1'b1;
      is_op: begin
        n_fn = opc[3:0];
        n_a  = src_a;
        n_b  = src_b;
      end
      is_opc: begin
        n_fn = opc[3:0];
        n_a  = src_a;
        n_b  = {{16{lit[15]}}, lit};
      end
    endcase
  end

  assign bus.in_ready = !bus.out_valid || bus.out_ready;

  // Regfile reads above see the pre-write value; writes land here.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.alu_fn    <= 4'h0;
      bus.op_a      <= 32'h0;
      bus.op_b      <= 32'h0;
      bus.rc        <= 5'd0;
      bus.illegal   <= 1'b0;
      for (int i = 0; i < 31; i++) rf[i] <= REG_INIT;
    end else begin
      if (bus.wb_en && (bus.wb_addr != 5'd31))
        rf[bus.wb_addr] <= bus.wb_data;
      if (bus.in_valid && bus.in_ready) begin
        bus.out_valid <= 1'b1;
        bus.alu_fn    <= n_fn;
        bus.op_a      <= n_a;
        bus.op_b      <= n_b;
        bus.rc        <= bus.instr[25:21];
        bus.illegal   <= n_ill;
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_beta_operand_stage.sv
// Bench for beta_operand_stage: directed cases then random traffic
// checked against a behavioural model of regfile and output register.
module tb_beta_operand_stage;

  localparam logic [31:0] INIT = 32'hA5A5_0001;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  beta_operand_stage_if bus ();

  beta_operand_stage #(.REG_INIT(INIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vecs = 0;
  int errs = 0;

  logic [31:0] mreg [32];
  logic        ev = 1'b0;
  logic [3:0]  efn;
  logic [31:0] ea;
  logic [31:0] eb;
  logic [4:0]  erc;
  logic        eill;
  bit          known = 1'b0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] src(input logic [4:0] i,
                                      input logic we,
                                      input logic [4:0] wa,
                                      input logic [31:0] wd);
    if (i == 5'd31) return 32'h0;
`ifdef BETA_OPERAND_BYPASS_EN
    if (we && wa == i) return wd;
`endif
    return mreg[i];
  endfunction

  function automatic logic [31:0] mk(input logic [5:0] op,
                                     input logic [4:0] c,
                                     input logic [4:0] a,
                                     input logic [4:0] b);
    return {op, c, a, b, 11'd0};
  endfunction

  function automatic logic [31:0] mki(input logic [5:0] op,
                                      input logic [4:0] c,
                                      input logic [4:0] a,
                                      input logic [15:0] l);
    return {op, c, a, l};
  endfunction

  // One clock: drive at negedge, model the edge, check at next negedge.
  task automatic cyc(input logic r, input logic iv,
                     input logic [31:0] ins, input logic we,
                     input logic [4:0] wa, input logic [31:0] wd,
                     input logic ordy);
    logic [5:0] op;
    logic       rdy;
    logic [3:0] f;
    rst = r;
    bus.in_valid  = iv;
    bus.instr     = ins;
    bus.wb_en     = we;
    bus.wb_addr   = wa;
    bus.wb_data   = wd;
    bus.out_ready = ordy;
    #1;
    rdy = !ev || ordy;
    if (known) check("in_ready", {31'd0, bus.in_ready}, {31'd0, rdy});
    if (r) begin
      ev = 0; efn = 0; ea = 0; eb = 0; erc = 0; eill = 0;
      foreach (mreg[i]) mreg[i] = (i == 31) ? 32'h0 : INIT;
      known = 1'b1;
    end else begin
      if (iv && rdy) begin
        op  = ins[31:26];
        f   = op[3:0];
        ev  = 1'b1;
        erc = ins[25:21];
        if (op < 6'h20 || f == 4'h3 || f == 4'h7 || f == 4'hF) begin
          eill = 1; efn = 0; ea = 0; eb = 0;
        end else begin
          eill = 0;
          efn  = f;
          ea   = src(ins[20:16], we, wa, wd);
          if (op >= 6'h30)
            eb = {{16{ins[15]}}, ins[15:0]};
          else
            eb = src(ins[15:11], we, wa, wd);
        end
      end else if (ordy) begin
        ev = 1'b0;
      end
      if (we && wa != 5'd31) mreg[wa] = wd;
    end
    @(posedge clk);
    @(negedge clk);
    if (known) begin
      check("out_valid", {31'd0, bus.out_valid}, {31'd0, ev});
      check("alu_fn", {28'd0, bus.alu_fn}, {28'd0, efn});
      check("op_a", bus.op_a, ea);
      check("op_b", bus.op_b, eb);
      check("rc", {27'd0, bus.rc}, {27'd0, erc});
      check("illegal", {31'd0, bus.illegal}, {31'd0, eill});
    end
  endtask

  initial begin
    logic [5:0] op;
    logic [31:0] ins;
    logic [31:0] sub_exp;
    rst = 1'b1;
    bus.in_valid = 0; bus.instr = 0; bus.wb_en = 0;
    bus.wb_addr = 0; bus.wb_data = 0; bus.out_ready = 0;
    @(negedge clk);

    cyc(1, 0, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 0, 1);
    check("rdy_after_rst", {31'd0, bus.in_ready}, 32'd1);

    cyc(0, 0, 0, 1, 5'd1, 32'd5, 1);
    cyc(0, 0, 0, 1, 5'd2, 32'd3, 1);
    cyc(0, 1, mk(6'h20, 3, 1, 2), 0, 0, 0, 1);
    check("add_v", {31'd0, bus.out_valid}, 32'd1);
    check("add_fn", {28'd0, bus.alu_fn}, 32'd0);
    check("add_a", bus.op_a, 32'd5);
    check("add_b", bus.op_b, 32'd3);
    check("add_rc", {27'd0, bus.rc}, 32'd3);

    cyc(0, 1, mki(6'h30, 5, 31, 16'hFFFE), 0, 0, 0, 1);
    check("addc_a", bus.op_a, 32'd0);
    check("addc_b", bus.op_b, 32'hFFFF_FFFE);
    check("addc_fn", {28'd0, bus.alu_fn}, 32'd0);

    cyc(0, 0, 0, 1, 5'd4, 32'd2, 1);
    cyc(0, 1, mk(6'h20, 6, 1, 2), 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 1, mk(6'h21, 7, 2, 1), 0, 0, 0, 0);
      check("stall_rdy", {31'd0, bus.in_ready}, 32'd0);
      check("stall_a", bus.op_a, 32'd5);
      check("stall_rc", {27'd0, bus.rc}, 32'd6);
    end
    cyc(0, 1, mk(6'h21, 7, 2, 1), 0, 0, 0, 1);
    check("resume_rc", {27'd0, bus.rc}, 32'd7);
    check("resume_a", bus.op_a, 32'd3);
    check("resume_fn", {28'd0, bus.alu_fn}, 32'd1);

`ifdef BETA_OPERAND_BYPASS_EN
    sub_exp = 32'd9;
`else
    sub_exp = 32'd2;
`endif
    cyc(0, 1, mk(6'h21, 8, 4, 1), 1, 5'd4, 32'd9, 1);
    check("sub_fwd_a", bus.op_a, sub_exp);
    cyc(0, 1, mki(6'h30, 8, 4, 16'h0), 0, 0, 0, 1);
    check("r4_new", bus.op_a, 32'd9);

    cyc(0, 1, {6'h23, 5'd9, 5'd1, 5'd2, 11'h7FF}, 0, 0, 0, 1);
    check("ill23", {31'd0, bus.illegal}, 32'd1);
    check("ill23_a", bus.op_a, 32'd0);
    check("ill23_b", bus.op_b, 32'd0);
    check("ill23_rc", {27'd0, bus.rc}, 32'd9);
    cyc(0, 1, {6'h01, 5'd10, 5'd1, 5'd2, 11'h7FF}, 0, 0, 0, 1);
    check("ill01", {31'd0, bus.illegal}, 32'd1);
    check("ill01_fn", {28'd0, bus.alu_fn}, 32'd0);

    cyc(0, 0, 0, 1, 5'd31, 32'd7, 1);
    cyc(0, 1, mk(6'h20, 11, 31, 31), 0, 0, 0, 1);
    check("r31_a", bus.op_a, 32'd0);
    check("r31_b", bus.op_b, 32'd0);

    cyc(0, 1, mk(6'h20, 12, 1, 2), 0, 0, 0, 0);
    cyc(1, 1, mk(6'h20, 13, 1, 2), 1, 5'd1, 32'd77, 0);
    check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    cyc(0, 1, mki(6'h30, 14, 1, 16'h0), 0, 0, 0, 1);
    check("rst_r1", bus.op_a, INIT);

    for (int k = 0; k < 400; k++) begin
      op = ($urandom_range(0, 7) == 0) ? 6'($urandom)
                                       : {1'b1, 5'($urandom)};
      ins = {op, 26'($urandom)};
      cyc($urandom_range(0, 49) == 0,
          $urandom_range(0, 9) < 7,
          ins,
          $urandom_range(0, 1) == 1,
          5'($urandom),
          $urandom,
          $urandom_range(0, 9) < 7);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
